// File: rtl/hazard_ctrl.sv
// Pipeline interlock and forwarding controller: load-use stalls, redirect flushes,
// registered operand-forward selects and the ECALL drain/halt sequence.
module hazard_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [6:0] d_opcode,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       e_valid,
    input  logic       e_regwrite,
    input  logic       e_memread,
    input  logic [4:0] e_rd,
    input  logic       m_valid,
    input  logic       m_regwrite,
    input  logic [4:0] m_rd,
    input  logic       br_taken,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t state;
    state_t next_state;
    logic   use_rs1;
    logic   use_rs2;
    logic   lu;
    logic   is_ecall;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (d_opcode)
            OP_R, OP_S, OP_B: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // e_rd != 0 also rules out x0 sources matching the load destination
    assign lu = d_valid & e_valid & e_memread & e_regwrite & (e_rd != 5'd0)
              & ((use_rs1 & (d_rs1 == e_rd)) | (use_rs2 & (d_rs2 == e_rd)));
    assign is_ecall = d_valid & (d_opcode == OP_ECALL);

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != 5'd0) begin
            if (e_valid && e_regwrite && e_rd == src)
                sel = 2'b01;
            else if (m_valid && m_regwrite && m_rd == src)
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (!br_taken && !lu && is_ecall) next_state = DRAIN;
            DRAIN:   if (!e_valid && !m_valid) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (br_taken) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (lu) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (is_ecall) begin
                        stall_f = 1'b1;
                        flush_d = 1'b1;
                    end
                end
                DRAIN: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                HALT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Selects describe the instruction entering EX, so a bubble gets 00
    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_a       <= 2'b00;
            fwd_b       <= 2'b00;
            halted      <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            if (flush_e || state != RUN) begin
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end else begin
                fwd_a <= fwd_sel(use_rs1, d_rs1);
                fwd_b <= fwd_sel(use_rs2, d_rs2);
            end
            halted <= (next_state == HALT);
            if (state == RUN && !br_taken && lu && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule
